// File: rtl/nested_int_ctrl.sv
// Nested interrupt controller: edge-detected pending latch, fixed-priority arbitration
// (higher index wins), req/ack handshake to the pipeline and an in-service nesting stack.
module nested_int_ctrl #(
  parameter int                N_CH        = 3,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE    = 'h0000_1000,
  parameter logic [ADDR_W-1:0] VEC_STRIDE  = 'h0000_0010,
  parameter bit                PREEMPT_REQ = 1'b1,
  localparam int               ID_W        = $clog2(N_CH),
  localparam int               DEPTH_W     = $clog2(N_CH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    irq_in,
  input  logic [N_CH-1:0]    irq_mask,
  input  logic               global_en,
  input  logic               hold,
  input  logic               int_ack,
  input  logic               eret,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  output logic [ADDR_W-1:0]  int_vec,
  output logic [N_CH-1:0]    pending,
  output logic [N_CH-1:0]    in_service,
  output logic [DEPTH_W-1:0] nest_depth
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t              state;
  logic [N_CH-1:0]     irq_prev;
  logic [N_CH-1:0]     eligible;
  logic [N_CH-1:0]     top_mask;
  logic [N_CH-1:0]     ack_mask;
  logic [ID_W-1:0]     winner;
  logic                any_eligible;
  logic                ack;
  logic [DEPTH_W-1:0]  depth;

  // Only channels strictly above the highest in-service channel may nest.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    eligible     = '0;
    top_mask     = '0;
    winner       = '0;
    any_eligible = 1'b0;
    depth        = '0;
    for (int i = 0; i < N_CH; i++) begin
      if ((in_service >> i) == '0) eligible[i] = pending[i] & irq_mask[i];
      if (eligible[i]) begin
        winner       = ID_W'(i);
        any_eligible = 1'b1;
      end
      if (in_service[i]) top_mask = N_CH'(1) << i;
      depth = depth + DEPTH_W'(in_service[i]);
    end
  end

  assign ack        = (state == S_REQ) & int_ack;
  assign ack_mask   = ack ? (N_CH'(1) << int_id) : '0;
  assign int_req    = (state == S_REQ);
  assign int_vec    = VEC_BASE + ADDR_W'(int_id) * VEC_STRIDE;
  assign nest_depth = depth;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state      <= S_IDLE;
      int_id     <= '0;
      irq_prev   <= '0;
      pending    <= '0;
      in_service <= '0;
    end else begin
      irq_prev   <= irq_in;
      // A fresh edge beats the ack clear, so an event arriving during acknowledgement survives.
      pending    <= (pending & ~ack_mask) | (irq_in & ~irq_prev);
      in_service <= (in_service & ~(eret ? top_mask : '0)) | ack_mask;
      case (state)
        S_IDLE: begin
          if (global_en && !hold && any_eligible) begin
            state  <= S_REQ;
            int_id <= winner;
          end
        end
        S_REQ: begin
          if (int_ack) state <= S_IDLE;
          else if (PREEMPT_REQ && any_eligible && (winner > int_id)) int_id <= winner;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nested_int_ctrl.sv
// Randomised + directed bench for nested_int_ctrl; two instances (preempting and locked
// int_id) are compared every cycle against a stack-based reference model via scoreboards.
module tb_nested_int_ctrl;

  localparam int N_CH = 3;
  localparam logic [31:0] VEC_BASE   = 32'h0000_1000;
  localparam logic [31:0] VEC_STRIDE = 32'h0000_0010;

  typedef struct packed {
    logic        req;
    logic [1:0]  id;
    logic [31:0] vec;
    logic [2:0]  pend;
    logic [2:0]  insv;
    logic [1:0]  depth;
  } exp_t;

  logic clk, rst, global_en, hold, int_ack, eret;
  logic [2:0] irq_in, irq_mask;

  logic p_req, n_req;
  logic [1:0] p_id, n_id, p_depth, n_depth;
  logic [31:0] p_vec, n_vec;
  logic [2:0] p_pend, n_pend, p_insv, n_insv;

  int n_checks = 0;
  int n_err = 0;

  exp_t q_p[$];
  exp_t q_n[$];

  // Reference model: in-service channels kept as a stack of ids, index 0 = preempting.
  bit       m_req[2];
  int       m_id[2];
  bit [2:0] m_pend[2];
  bit [2:0] m_prev[2];
  int       m_stk[2][N_CH];
  int       m_depth[2];

  nested_int_ctrl #(.N_CH(N_CH), .ADDR_W(32), .VEC_BASE(VEC_BASE), .VEC_STRIDE(VEC_STRIDE),
                    .PREEMPT_REQ(1'b1)) dut_p (
    .clk(clk), .rst(rst), .irq_in(irq_in), .irq_mask(irq_mask), .global_en(global_en),
    .hold(hold), .int_ack(int_ack), .eret(eret), .int_req(p_req), .int_id(p_id),
    .int_vec(p_vec), .pending(p_pend), .in_service(p_insv), .nest_depth(p_depth));

  nested_int_ctrl #(.N_CH(N_CH), .ADDR_W(32), .VEC_BASE(VEC_BASE), .VEC_STRIDE(VEC_STRIDE),
                    .PREEMPT_REQ(1'b0)) dut_n (
    .clk(clk), .rst(rst), .irq_in(irq_in), .irq_mask(irq_mask), .global_en(global_en),
    .hold(hold), .int_ack(int_ack), .eret(eret), .int_req(n_req), .int_id(n_id),
    .int_vec(n_vec), .pending(n_pend), .in_service(n_insv), .nest_depth(n_depth));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input bit preempt);
    int top, win, old_id;
    bit ack;
    if (rst) begin
      m_req[k] = 0; m_id[k] = 0; m_pend[k] = '0; m_prev[k] = '0; m_depth[k] = 0;
      return;
    end
    top = (m_depth[k] > 0) ? m_stk[k][m_depth[k]-1] : -1;
    win = -1;
    for (int ch = 0; ch < N_CH; ch++)
      if (m_pend[k][ch] && irq_mask[ch] && ch > top) win = ch;
    ack    = m_req[k] && int_ack;
    old_id = m_id[k];
    if (!m_req[k]) begin
      if (global_en && !hold && win >= 0) begin
        m_req[k] = 1;
        m_id[k]  = win;
      end
    end else if (ack) m_req[k] = 0;
    else if (preempt && win > m_id[k]) m_id[k] = win;
    if (eret && m_depth[k] > 0) m_depth[k]--;
    if (ack && m_depth[k] < N_CH) begin
      m_stk[k][m_depth[k]] = old_id;
      m_depth[k]++;
    end
    for (int ch = 0; ch < N_CH; ch++)
      m_pend[k][ch] = (m_pend[k][ch] && !(ack && ch == old_id)) || (irq_in[ch] && !m_prev[k][ch]);
    m_prev[k] = irq_in;
  endtask

  function automatic exp_t expect_of(input int k);
    exp_t e;
    e.req  = m_req[k];
    e.id   = 2'(m_id[k]);
    e.vec  = VEC_BASE + 32'(m_id[k]) * VEC_STRIDE;
    e.pend = m_pend[k];
    e.insv = '0;
    for (int d = 0; d < m_depth[k]; d++) e.insv[m_stk[k][d]] = 1'b1;
    e.depth = 2'(m_depth[k]);
    return e;
  endfunction

  // One clock: apply inputs at the falling edge, step the model at the rising edge.
  task automatic cyc(input logic [2:0] irq, input bit ack = 0, input bit er = 0,
                     input bit hl = 0, input bit rs = 0, input logic [2:0] mask = 3'b111,
                     input bit ge = 1);
    irq_in = irq; int_ack = ack; eret = er; hold = hl; rst = rs; irq_mask = mask; global_en = ge;
    @(posedge clk);
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    q_p.push_back(expect_of(0));
    q_n.push_back(expect_of(1));
    @(negedge clk);
  endtask

  task automatic compare(input string tag, input exp_t e, input exp_t a);
    check({tag, "_int_req"},    32'(a.req),   32'(e.req));
    check({tag, "_int_id"},     32'(a.id),    32'(e.id));
    check({tag, "_int_vec"},    a.vec,        e.vec);
    check({tag, "_pending"},    32'(a.pend),  32'(e.pend));
    check({tag, "_in_service"}, 32'(a.insv),  32'(e.insv));
    check({tag, "_nest_depth"}, 32'(a.depth), 32'(e.depth));
  endtask

  // Monitor: pops the scoreboard on every falling edge, independent of the stimulus.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q_p.size() > 0) begin
        e = q_p.pop_front();
        compare("p", e, {p_req, p_id, p_vec, p_pend, p_insv, p_depth});
      end
      while (q_n.size() > 0) begin
        e = q_n.pop_front();
        compare("n", e, {n_req, n_id, n_vec, n_pend, n_insv, n_depth});
      end
    end
  end

  initial begin
    logic [2:0] irq_r;
    cyc(3'b000, .rs(1));
    cyc(3'b000, .rs(1));
    check("rst_req", 32'(p_req), 0);
    check("rst_pend", 32'(p_pend), 0);
    check("rst_insv", 32'(p_insv), 0);

    // First request latency and vector.
    cyc(3'b010);
    check("t1_pend", 32'(p_pend), 32'h2);
    check("t1_req_early", 32'(p_req), 0);
    cyc(3'b010);
    check("t1_req", 32'(p_req), 1);
    check("t1_id", 32'(p_id), 1);
    check("t1_vec", p_vec, 32'h1010);
    cyc(3'b010, .ack(1));
    check("t1_insv", 32'(p_insv), 32'h2);

    // Nesting: only the higher channel is requested.
    cyc(3'b111);
    cyc(3'b111);
    check("t2_id", 32'(p_id), 2);
    cyc(3'b111, .ack(1));
    check("t2_insv", 32'(p_insv), 32'h6);
    check("t2_depth", 32'(p_depth), 2);
    check("t2_pend", 32'(p_pend), 32'h1);
    cyc(3'b111);
    check("t2_no_req", 32'(p_req), 0);

    // Unwind two levels, then ch0 is requested.
    cyc(3'b111, .er(1));
    check("t3_insv1", 32'(p_insv), 32'h2);
    cyc(3'b111, .er(1));
    check("t3_insv0", 32'(p_insv), 32'h0);
    cyc(3'b111);
    check("t3_req", 32'(p_req), 1);
    check("t3_id", 32'(p_id), 0);
    cyc(3'b111, .ack(1));
    cyc(3'b111, .er(1));

    // Preemption of an unacked request versus locked int_id.
    cyc(3'b000);
    cyc(3'b000);
    cyc(3'b001);
    cyc(3'b001);
    cyc(3'b101);
    cyc(3'b101);
    check("t4_p_id", 32'(p_id), 2);
    check("t4_p_req", 32'(p_req), 1);
    check("t4_p_vec", p_vec, 32'h1020);
    check("t4_n_id", 32'(n_id), 0);
    cyc(3'b101, .ack(1));
    cyc(3'b000, .rs(1));

    // Hold blocks IDLE->REQ; masked channel stays pending.
    cyc(3'b010, .hl(1));
    cyc(3'b010, .hl(1));
    cyc(3'b010, .hl(1));
    check("t5_hold", 32'(p_req), 0);
    cyc(3'b010);
    check("t5_release", 32'(p_req), 1);
    cyc(3'b010, .ack(1));
    cyc(3'b010, .er(1));
    cyc(3'b000, .mask(3'b101));
    for (int i = 0; i < 4; i++) cyc(3'b010, .mask(3'b101));
    check("t5_masked_req", 32'(p_req), 0);
    check("t5_masked_pend", 32'(p_pend), 32'h2);

    // Ack and new edge on the same channel; reset while requesting.
    cyc(3'b000, .rs(1));
    cyc(3'b010);
    cyc(3'b010);
    cyc(3'b000);
    cyc(3'b010, .ack(1));
    check("t6_pend_kept", 32'(p_pend), 32'h2);
    check("t6_insv", 32'(p_insv), 32'h2);
    cyc(3'b010, .er(1));
    cyc(3'b010);
    check("t6_req", 32'(p_req), 1);
    cyc(3'b010, .rs(1));
    check("t6_rst_req", 32'(p_req), 0);
    check("t6_rst_pend", 32'(p_pend), 0);
    check("t6_rst_id", 32'(p_id), 0);

    // Random traffic.
    irq_r = 3'b010;
    for (int c = 0; c < 3000; c++) begin
      irq_r = irq_r ^ 3'($urandom_range(0, 7) & $urandom_range(0, 7));
      cyc(irq_r, ($urandom_range(0, 9) < 3), ($urandom_range(0, 11) == 0),
          ($urandom_range(0, 6) == 0), ($urandom_range(0, 199) == 0),
          ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b111,
          ($urandom_range(0, 9) != 0));
    end

    @(negedge clk);
    check("scoreboard_drained", q_p.size() + q_n.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
